if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL expose parameter: RESET_PC, 32'h0000_0000, address of first fetch after reset.
REQ-002 SHALL have port: clk  in  1  system clock; single clock domain, rising edge.
REQ-003 SHALL have port: rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port: stall  in  1  decode stage cannot accept a new IF/ID entry this cycle.
REQ-005 SHALL have port: pc_src  in  1  taken branch/jump redirect from execute.
REQ-006 SHALL have port: pc_target  in  32  redirect address; bits [1:0] ignored.
REQ-007 SHALL have port: imem_req_valid  out  1  instruction-memory request valid.
REQ-008 SHALL have port: imem_req_ready  in  1  memory accepts request this cycle.
REQ-009 SHALL have port: imem_addr  out  32  word-aligned fetch address (= PC).
REQ-010 SHALL have port: imem_resp_valid  in  1  response data valid.
REQ-011 SHALL have port: imem_resp_data  in  32  fetched instruction word.
REQ-012 SHALL have ports: id_instr out 32, id_pc out 32, id_pc_plus4 out 32, id_valid out 1 -- IF/ID register feeding the decoder (id_instr[6:0] is the opcode).

Function
REQ-013 SHALL keep PC[1:0] = 2'b00 at all times; pc_target[1:0] discarded.
REQ-014 SHALL implement FSM states REQ, WAIT, HOLD; at most one memory request outstanding.
REQ-015 REQ: imem_req_valid=1, imem_addr=PC; on imem_req_ready -> WAIT. imem_addr may change between cycles while unaccepted (port has no address-stability rule).
REQ-016 WAIT: imem_req_valid=0; on imem_resp_valid with kill=0: if !stall or !id_valid, load IF/ID {data, PC, PC+4, valid=1}, PC<=PC+4, -> REQ; else capture {data, PC} in skid buffer, PC<=PC+4, -> HOLD.
REQ-017 HOLD: imem_req_valid=0; when stall=0, load IF/ID from skid buffer, -> REQ.
REQ-018 When stall=1 and no redirect, IF/ID contents SHALL hold unchanged.
REQ-019 When stall=0 and no new entry is loaded, id_valid SHALL go to 0 and id_instr to NOP 32'h0000_0013.
REQ-020 pc_src=1 SHALL take priority over stall and response: PC<=pc_target&~3, id_valid<=0, id_instr<=NOP; skid buffer discarded.
REQ-021 Redirect in REQ without ready: next cycle requests new PC. Redirect in REQ with ready same cycle: set kill, -> WAIT.
REQ-022 Redirect in WAIT: set kill, remain WAIT; response arriving with kill=1 SHALL be dropped, kill cleared, -> REQ with redirected PC. Redirect coinciding with response in WAIT: response dropped, -> REQ, kill stays 0.
REQ-023 Redirect in HOLD: -> REQ.
REQ-024 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-025 Minimum throughput: one instruction per 2 cycles with zero-latency ready and 1-cycle response.

Reset
REQ-026 On rst: PC=RESET_PC, state=REQ, kill=0, id_valid=0, id_instr=32'h0000_0013, id_pc=0, id_pc_plus4=0, skid buffer cleared.
REQ-027 imem_req_valid SHALL be 0 while rst=1; first request in the first cycle after deassertion.
REQ-028 Reset asserted mid-transaction SHALL abandon it; a late response after reset while in REQ SHALL be ignored.

Structure
REQ-029 fetch_state_t enum, NOP_INSTR constant and instruction-width constant SHALL reside in package rv32i_defs.
REQ-030 IF/ID register SHALL be a sub-module if_id_reg (load, flush, hold); PC, FSM, skid buffer in if_stage.

Verification
REQ-031 Reset release, RESET_PC=0, ready=1, 1-cycle response data 0x00500093 -> id_valid=1, id_instr=0x00500093, id_pc=0, id_pc_plus4=4; next imem_addr=4.
REQ-032 Stall held 3 cycles while response 0x00000013@PC=8 arrives with id_valid=1 -> HOLD, IF/ID unchanged, entry appears the cycle after stall drops, no imem request during HOLD.
REQ-033 pc_src=1, pc_target=0x103 in WAIT, stale response 0xDEADBEEF arrives -> dropped, id_valid=0, next imem_addr=0x100.
REQ-034 pc_src and stall both 1 with id_valid=1 -> id_valid=0, id_instr=0x00000013 next cycle.
REQ-035 PC=0xFFFFFFFC fetch -> id_pc_plus4=0, next imem_addr=0.
REQ-036 rst asserted while WAIT with response pending -> outputs to reset values immediately; first post-reset imem_addr=RESET_PC.

Source files
------------

// File: rtl/rv32i_defs.sv
// rtl/rv32i_defs.sv - shared RV32I fetch definitions: widths, NOP encoding, fetch FSM states
//
// Purpose: constants and types shared by the fetch stage and its IF/ID register.
// Contents:
//   ILEN          instruction width in bits
//   NOP_INSTR     canonical NOP (addi x0, x0, 0) used for bubbles and reset
//   fetch_state_t fetch FSM encoding (request / wait for response / hold in skid buffer)
//   word_align    clears the two low address bits
package rv32i_defs;

  localparam int ILEN = 32;

  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_HOLD = 2'd2
  } fetch_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with load, flush and hold
//
// Purpose: holds the instruction handed from fetch to decode.
// Ports:
//   clk, rst                      rising-edge clock, asynchronous active-high reset
//   load                          capture instr_in/pc_in/pc_plus4_in as a valid entry
//   flush                         turn the entry into a bubble (wins over load)
//   instr_in, pc_in, pc_plus4_in  entry to capture
//   id_instr, id_pc, id_pc_plus4  registered entry presented to decode
//   id_valid                      entry is a real instruction
// With neither load nor flush the register holds its contents.
module if_id_reg
  import rv32i_defs::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            flush,
  input  logic [ILEN-1:0] instr_in,
  input  logic [31:0]     pc_in,
  input  logic [31:0]     pc_plus4_in,
  output logic [ILEN-1:0] id_instr,
  output logic [31:0]     id_pc,
  output logic [31:0]     id_pc_plus4,
  output logic            id_valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_instr    <= NOP_INSTR;
      id_pc       <= 32'h0000_0000;
      id_pc_plus4 <= 32'h0000_0000;
      id_valid    <= 1'b0;
    end else if (flush) begin
      // Bubble: only valid and the opcode matter downstream, PC fields are left as-is.
      id_instr <= NOP_INSTR;
      id_valid <= 1'b0;
    end else if (load) begin
      id_instr    <= instr_in;
      id_pc       <= pc_in;
      id_pc_plus4 <= pc_plus4_in;
      id_valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - RV32I instruction fetch stage: PC, fetch FSM, skid buffer, IF/ID register
//
// Purpose: issues one instruction-memory request at a time and delivers fetched
// words into the IF/ID register, absorbing decode back-pressure with a one-entry
// skid buffer and honouring branch/jump redirects from execute.
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   stall                    decode cannot accept a new IF/ID entry this cycle
//   pc_src, pc_target        redirect request and target (low two bits ignored)
//   imem_req_valid/ready     request handshake; imem_addr is the current PC
//   imem_resp_valid/data     response for the outstanding request
//   id_instr, id_pc,
//   id_pc_plus4, id_valid    IF/ID register outputs feeding decode
module if_stage
  import rv32i_defs::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            pc_src,
  input  logic [31:0]     pc_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [31:0]     imem_addr,
  input  logic            imem_resp_valid,
  input  logic [ILEN-1:0] imem_resp_data,
  output logic [ILEN-1:0] id_instr,
  output logic [31:0]     id_pc,
  output logic [31:0]     id_pc_plus4,
  output logic            id_valid
);

  fetch_state_t    state, state_nx;
  logic [31:0]     pc, pc_nx;
  logic            kill, kill_nx;
  logic [ILEN-1:0] skid_instr, skid_instr_nx;
  logic [31:0]     skid_pc, skid_pc_nx;

  logic            ifid_load;
  logic            ifid_flush;
  logic [ILEN-1:0] ifid_instr_in;
  logic [31:0]     ifid_pc_in;
  logic [31:0]     ifid_pc_plus4_in;
  logic [31:0]     pc_plus4;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;

  // The async reset forces state to REQ, so gate with rst to keep the request low during reset.
  assign imem_req_valid = (state == FETCH_REQ) && !rst;

  always_comb begin
    state_nx      = state;
    pc_nx         = pc;
    kill_nx       = kill;
    skid_instr_nx = skid_instr;
    skid_pc_nx    = skid_pc;
    ifid_load     = 1'b0;
    ifid_instr_in = imem_resp_data;
    ifid_pc_in    = pc;

    if (pc_src) begin
      pc_nx         = word_align(pc_target);
      skid_instr_nx = NOP_INSTR;
      skid_pc_nx    = 32'h0000_0000;
      unique case (state)
        FETCH_REQ: begin
          // A request accepted this same cycle was for the old PC; its response must be dropped.
          if (imem_req_ready) begin
            state_nx = FETCH_WAIT;
            kill_nx  = 1'b1;
          end
        end
        FETCH_WAIT: begin
          if (imem_resp_valid) begin
            // The stale response is consumed right now, nothing left to kill.
            state_nx = FETCH_REQ;
            kill_nx  = 1'b0;
          end else begin
            kill_nx = 1'b1;
          end
        end
        FETCH_HOLD: begin
          state_nx = FETCH_REQ;
          kill_nx  = 1'b0;
        end
        default: begin
          state_nx = FETCH_REQ;
          kill_nx  = 1'b0;
        end
      endcase
    end else begin
      unique case (state)
        FETCH_REQ: begin
          if (imem_req_ready) state_nx = FETCH_WAIT;
        end
        FETCH_WAIT: begin
          if (imem_resp_valid) begin
            if (kill) begin
              kill_nx  = 1'b0;
              state_nx = FETCH_REQ;
            end else if (!stall || !id_valid) begin
              // An empty IF/ID slot can be filled even while decode reports stall.
              ifid_load = 1'b1;
              pc_nx     = pc_plus4;
              state_nx  = FETCH_REQ;
            end else begin
              skid_instr_nx = imem_resp_data;
              skid_pc_nx    = pc;
              pc_nx         = pc_plus4;
              state_nx      = FETCH_HOLD;
            end
          end
        end
        FETCH_HOLD: begin
          if (!stall) begin
            ifid_load     = 1'b1;
            ifid_instr_in = skid_instr;
            ifid_pc_in    = skid_pc;
            state_nx      = FETCH_REQ;
          end
        end
        default: begin
          state_nx = FETCH_REQ;
          kill_nx  = 1'b0;
        end
      endcase
    end
  end

  assign ifid_pc_plus4_in = ifid_pc_in + 32'd4;

  // A redirect always squashes; otherwise an unstalled cycle without a new entry becomes a bubble.
  assign ifid_flush = pc_src || (!stall && !ifid_load);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FETCH_REQ;
      pc         <= word_align(RESET_PC);
      kill       <= 1'b0;
      skid_instr <= NOP_INSTR;
      skid_pc    <= 32'h0000_0000;
    end else begin
      state      <= state_nx;
      pc         <= pc_nx;
      kill       <= kill_nx;
      skid_instr <= skid_instr_nx;
      skid_pc    <= skid_pc_nx;
    end
  end

  if_id_reg u_if_id_reg (
    .clk         (clk),
    .rst         (rst),
    .load        (ifid_load),
    .flush       (ifid_flush),
    .instr_in    (ifid_instr_in),
    .pc_in       (ifid_pc_in),
    .pc_plus4_in (ifid_pc_plus4_in),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_pc_plus4 (id_pc_plus4),
    .id_valid    (id_valid)
  );

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        pc_src;
  logic [31:0] pc_target;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        id_valid;

  int checks = 0;
  int errors = 0;

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .pc_src          (pc_src),
    .pc_target       (pc_target),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .id_instr        (id_instr),
    .id_pc           (id_pc),
    .id_pc_plus4     (id_pc_plus4),
    .id_valid        (id_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_id(input string tag, input logic v, input logic [31:0] ins,
                          input logic [31:0] p, input logic [31:0] p4);
    check({tag, ".id_valid"}, {31'b0, id_valid}, {31'b0, v});
    check({tag, ".id_instr"}, id_instr, ins);
    check({tag, ".id_pc"}, id_pc, p);
    check({tag, ".id_pc_plus4"}, id_pc_plus4, p4);
  endtask

  task automatic check_req(input string tag, input logic v, input logic [31:0] addr);
    check({tag, ".req_valid"}, {31'b0, imem_req_valid}, {31'b0, v});
    check({tag, ".imem_addr"}, imem_addr, addr);
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    pc_src = 1'b0;
    pc_target = 32'h0;
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data = 32'h0;

    tick();
    tick();
    check_req("reset", 1'b0, 32'h0);
    check_id("reset", 1'b0, 32'h0000_0013, 32'h0, 32'h0);

    // First fetch after reset: accept immediately, respond one cycle later.
    rst = 1'b0;
    #1;
    check_req("post_reset", 1'b1, 32'h0);
    imem_req_ready = 1'b1;
    tick();
    check_req("wait0", 1'b0, 32'h0);
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'h0050_0093;
    tick();
    imem_resp_valid = 1'b0;
    check_id("first", 1'b1, 32'h0050_0093, 32'h0, 32'h4);
    check_req("first", 1'b1, 32'h4);

    // Second fetch at PC=4; the REQ cycle without stall bubbles IF/ID.
    tick();
    check("bubble.id_valid", {31'b0, id_valid}, 32'h0);
    check("bubble.id_instr", id_instr, 32'h0000_0013);
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'h0010_0113;
    tick();
    imem_resp_valid = 1'b0;
    check_id("second", 1'b1, 32'h0010_0113, 32'h4, 32'h8);
    check_req("second", 1'b1, 32'h8);

    // Stall for three cycles while the PC=8 response arrives: goes through the skid buffer.
    stall = 1'b1;
    tick();
    check_id("stall_req", 1'b1, 32'h0010_0113, 32'h4, 32'h8);
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'h0000_0013;
    tick();
    imem_resp_valid = 1'b0;
    check_id("hold1", 1'b1, 32'h0010_0113, 32'h4, 32'h8);
    check_req("hold1", 1'b0, 32'hC);
    tick();
    check_id("hold2", 1'b1, 32'h0010_0113, 32'h4, 32'h8);
    check_req("hold2", 1'b0, 32'hC);
    stall = 1'b0;
    tick();
    check_id("unhold", 1'b1, 32'h0000_0013, 32'h8, 32'hC);
    check_req("unhold", 1'b1, 32'hC);

    // Redirect while waiting; the stale response must be dropped.
    tick();
    pc_src = 1'b1;
    pc_target = 32'h0000_0103;
    tick();
    pc_src = 1'b0;
    check_req("kill_wait", 1'b0, 32'h100);
    check("kill_wait.id_valid", {31'b0, id_valid}, 32'h0);
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'hDEAD_BEEF;
    tick();
    imem_resp_valid = 1'b0;
    check("drop.id_valid", {31'b0, id_valid}, 32'h0);
    check("drop.id_instr", id_instr, 32'h0000_0013);
    check_req("drop", 1'b1, 32'h100);

    // Fetch at 0x100, then redirect and stall together with a valid entry.
    tick();
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'h0020_8193;
    tick();
    imem_resp_valid = 1'b0;
    check_id("at100", 1'b1, 32'h0020_8193, 32'h100, 32'h104);
    stall = 1'b1;
    pc_src = 1'b1;
    pc_target = 32'hFFFF_FFFC;
    imem_req_ready = 1'b0;
    tick();
    stall = 1'b0;
    pc_src = 1'b0;
    check("flush_stall.id_valid", {31'b0, id_valid}, 32'h0);
    check("flush_stall.id_instr", id_instr, 32'h0000_0013);
    check_req("redirect_req", 1'b1, 32'hFFFF_FFFC);

    // PC+4 wraps at the top of the address space.
    imem_req_ready = 1'b1;
    tick();
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'h0000_006F;
    tick();
    imem_resp_valid = 1'b0;
    check_id("wrap", 1'b1, 32'h0000_006F, 32'hFFFF_FFFC, 32'h0);
    check_req("wrap", 1'b1, 32'h0);

    // Redirect in REQ while the request is accepted: response must be killed.
    pc_src = 1'b1;
    pc_target = 32'h0000_0200;
    tick();
    pc_src = 1'b0;
    check_req("kill_req", 1'b0, 32'h200);
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'h1111_1111;
    tick();
    imem_resp_valid = 1'b0;
    check("kill_req.id_instr", id_instr, 32'h0000_0013);
    check_req("kill_req_done", 1'b1, 32'h200);

    // Redirect coinciding with the response: dropped, and no kill left behind.
    tick();
    pc_src = 1'b1;
    pc_target = 32'h0000_0300;
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'h2222_2222;
    tick();
    pc_src = 1'b0;
    imem_resp_valid = 1'b0;
    check("coincide.id_valid", {31'b0, id_valid}, 32'h0);
    check_req("coincide", 1'b1, 32'h300);
    tick();
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'h0000_0073;
    tick();
    imem_resp_valid = 1'b0;
    check_id("after_coincide", 1'b1, 32'h0000_0073, 32'h300, 32'h304);

    // Reset asserted while waiting for a response.
    tick();
    check_req("pre_reset_wait", 1'b0, 32'h304);
    rst = 1'b1;
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'hBADB_AD00;
    #1;
    check_req("async_reset", 1'b0, 32'h0);
    check_id("async_reset", 1'b0, 32'h0000_0013, 32'h0, 32'h0);
    tick();
    rst = 1'b0;
    imem_req_ready = 1'b0;
    #1;
    check_req("rerelease", 1'b1, 32'h0);
    tick();
    imem_resp_valid = 1'b0;
    check_req("late_resp", 1'b1, 32'h0);
    check("late_resp.id_valid", {31'b0, id_valid}, 32'h0);
    check("late_resp.id_instr", id_instr, 32'h0000_0013);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
